led_counter_sequencer: RTL and testbench

LED_COUNTER_SEQUENCER -- requirements
Module: led_counter_sequencer

---
 rtl/led_counter_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_led_counter_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter_sequencer.sv
// ---------------------------------------------------------------------------
// LedCounterSequencer: push-button driven run/pause/step sequencer for an
// external counter.
//
// Purpose:
//   A raw push-button and a raw mode switch are synchronized and debounced.
//   Each debounced button press advances a four-state FSM
//   (IDLE -> RUN -> PAUSE -> ... -> DONE -> IDLE).
//   In RUN, a prescaler emits a counter-enable strobe every PRESCALE cycles.
//   In PAUSE with the switch high, each press emits a single step strobe.
//   Reaching LIMIT on the external counter moves the FSM to DONE. A press in
//   DONE clears the counter and returns to IDLE.
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst_n    in   synchronous active-low reset
//   btn_in   in   raw asynchronous push-button, active-high
//   sw_in    in   raw asynchronous mode switch (1 = single-step, 0 = continuous)
//   ctr_val  in   current value of the external counter
//   ctr_en   out  one-cycle increment strobe to the external counter
//   ctr_clr  out  one-cycle clear strobe to the external counter
//   state    out  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3
//   done     out  high exactly while state is DONE
// ---------------------------------------------------------------------------
module led_counter_sequencer #(
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   PRESCALE        = 3,
    parameter int                   CTR_WIDTH       = 16,
    parameter logic [CTR_WIDTH-1:0] LIMIT           = CTR_WIDTH'(5)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_in,
    input  logic                 sw_in,
    input  logic [CTR_WIDTH-1:0] ctr_val,
    output logic                 ctr_en,
    output logic                 ctr_clr,
    output logic [1:0]           state,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic           r_btnSync1;
    logic           r_btnSync2;
    logic           r_swSync1;
    logic           r_swSync2;
    logic           r_btnDeb;
    logic           r_swDeb;
    logic [DBW-1:0] r_btnCnt;
    logic [DBW-1:0] r_swCnt;
    logic           r_btnDebDly;
    logic           r_press;

    seqState_t      r_state;
    logic [PSW-1:0] r_prescale;
    logic           r_ctrEn;
    logic           r_ctrClr;
    logic           r_done;

    seqState_t      w_nextState;
    logic [PSW-1:0] w_nextPrescale;
    logic           w_nextEn;
    logic           w_nextClr;
    logic [CTR_WIDTH-1:0] w_effVal;
    logic           w_atLimit;

    // Input conditioning: two-flop synchronizers, then a debouncer per input
    // that only accepts a new level after DEBOUNCE_CYCLES consecutive
    // disagreeing samples. The press pulse is the registered rising edge of
    // the debounced button, so the FSM acts one cycle after it is raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btnSync1  <= 1'b0;
            r_btnSync2  <= 1'b0;
            r_swSync1   <= 1'b0;
            r_swSync2   <= 1'b0;
            r_btnDeb    <= 1'b0;
            r_swDeb     <= 1'b0;
            r_btnCnt    <= '0;
            r_swCnt     <= '0;
            r_btnDebDly <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_btnSync1 <= btn_in;
            r_btnSync2 <= r_btnSync1;
            r_swSync1  <= sw_in;
            r_swSync2  <= r_swSync1;

            if (r_btnSync2 != r_btnDeb) begin
                if (r_btnCnt == DB_LAST) begin
                    r_btnDeb <= r_btnSync2;
                    r_btnCnt <= '0;
                end else begin
                    r_btnCnt <= r_btnCnt + DBW'(1);
                end
            end else begin
                r_btnCnt <= '0;
            end

            if (r_swSync2 != r_swDeb) begin
                if (r_swCnt == DB_LAST) begin
                    r_swDeb <= r_swSync2;
                    r_swCnt <= '0;
                end else begin
                    r_swCnt <= r_swCnt + DBW'(1);
                end
            end else begin
                r_swCnt <= '0;
            end

            r_btnDebDly <= r_btnDeb;
            r_press     <= r_btnDeb & ~r_btnDebDly;
        end
    end

    // The counter lags our strobe by one edge, so a strobe still in flight
    // counts towards the limit; otherwise back-to-back strobes could
    // overshoot LIMIT.
    assign w_effVal  = ctr_val + CTR_WIDTH'(r_ctrEn);
    assign w_atLimit = (ctr_val == LIMIT) || (w_effVal == LIMIT);

    // Next-state and next-output logic. A strobe that would fire at the
    // limit is swallowed and replaced by the move to DONE, which also wins
    // over a simultaneous press. A press on the same cycle as a due
    // (non-terminal) prescale strobe still lets that strobe out.
    always_comb begin
        w_nextState    = r_state;
        w_nextPrescale = '0;
        w_nextEn       = 1'b0;
        w_nextClr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_press) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (r_prescale == PS_LAST) begin
                    if (w_atLimit) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextEn = 1'b1;
                        if (r_press) begin
                            w_nextState = PAUSE;
                        end
                    end
                end else if (r_press) begin
                    w_nextState = PAUSE;
                end else begin
                    w_nextPrescale = r_prescale + PSW'(1);
                end
            end
            PAUSE: begin
                if (r_press) begin
                    if (r_swDeb) begin
                        if (w_atLimit) begin
                            w_nextState = DONE;
                        end else begin
                            w_nextEn = 1'b1;
                        end
                    end else begin
                        w_nextState = RUN;
                    end
                end
            end
            DONE: begin
                if (r_press) begin
                    w_nextState = IDLE;
                    w_nextClr   = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, prescaler and all outputs are registered so nothing reaches the
    // ports combinationally from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prescale <= '0;
            r_ctrEn    <= 1'b0;
            r_ctrClr   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_prescale <= w_nextPrescale;
            r_ctrEn    <= w_nextEn;
            r_ctrClr   <= w_nextClr;
            r_done     <= (w_nextState == DONE);
        end
    end

    assign ctr_en  = r_ctrEn;
    assign ctr_clr = r_ctrClr;
    assign state   = r_state;
    assign done    = r_done;

endmodule

// File: tb/tb_led_counter_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for led_counter_sequencer. Directed scenarios plus a randomized
// phase, all compared every cycle against a behavioural model of the
// sequencer; the bench also plays the external counter.
// ---------------------------------------------------------------------------
module tb_led_counter_sequencer;

    localparam int DEB = 4;
    localparam int PRE = 3;
    localparam int W   = 16;
    localparam int LIM = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_in = 1'b0;
    logic         sw_in = 1'b0;
    logic [W-1:0] ctr_val = '0;
    logic         ctr_en;
    logic         ctr_clr;
    logic [1:0]   state;
    logic         done;

    int checks = 0;
    int failures = 0;

    // External counter played by the bench
    int   envCount = 0;
    logic envEn;
    logic envClr;

    // Observed tallies
    int enPulses = 0;
    int clrPulses = 0;
    int enAtLimit = 0;
    bit curSw = 1'b0;

    // Behavioural model: raw samples one/two edges ago, accepted levels,
    // mismatch run lengths, debounced button history for the press edge,
    // then the sequencer itself.
    int mBtnRaw1, mBtnRaw2, mSwRaw1, mSwRaw2;
    int mBtnDeb, mSwDeb, mBtnRun, mSwRun;
    int mDebPrev1, mDebPrev2;
    int mMode, mRunAge, mCount, mEn, mClr;

    always #5 clk = ~clk;

    led_counter_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .PRESCALE(PRE),
        .CTR_WIDTH(W),
        .LIMIT(16'(LIM))
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .sw_in(sw_in),
        .ctr_val(ctr_val),
        .ctr_en(ctr_en),
        .ctr_clr(ctr_clr),
        .state(state),
        .done(done)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance the model across one clock edge given the sampled inputs.
    task automatic modelEdge(input bit b, input bit s, input bit r);
        int press;
        int eff;
        int nEn;
        int nClr;
        if (!r) begin
            mBtnRaw1 = 0; mBtnRaw2 = 0; mSwRaw1 = 0; mSwRaw2 = 0;
            mBtnDeb = 0; mSwDeb = 0; mBtnRun = 0; mSwRun = 0;
            mDebPrev1 = 0; mDebPrev2 = 0;
            mMode = 0; mRunAge = 0; mCount = 0; mEn = 0; mClr = 0;
        end else begin
            press = (mDebPrev1 == 1 && mDebPrev2 == 0) ? 1 : 0;
            eff = mCount + mEn;
            nEn = 0;
            nClr = 0;
            case (mMode)
                0: if (press == 1) begin mMode = 1; mRunAge = 0; end
                1: begin
                    mRunAge++;
                    if (mRunAge % PRE == 0) begin
                        if (eff >= LIM) mMode = 3;
                        else begin
                            nEn = 1;
                            if (press == 1) mMode = 2;
                        end
                    end else if (press == 1) begin
                        mMode = 2;
                    end
                end
                2: if (press == 1) begin
                    if (mSwDeb == 1) begin
                        if (eff >= LIM) mMode = 3;
                        else nEn = 1;
                    end else begin
                        mMode = 1;
                        mRunAge = 0;
                    end
                end
                default: if (press == 1) begin mMode = 0; nClr = 1; end
            endcase
            if (mClr == 1) mCount = 0;
            else if (mEn == 1) mCount++;
            mEn = nEn;
            mClr = nClr;

            mDebPrev2 = mDebPrev1;
            mDebPrev1 = mBtnDeb;
            if (mBtnRaw2 != mBtnDeb) begin
                mBtnRun++;
                if (mBtnRun == DEB) begin mBtnDeb = mBtnRaw2; mBtnRun = 0; end
            end else begin
                mBtnRun = 0;
            end
            if (mSwRaw2 != mSwDeb) begin
                mSwRun++;
                if (mSwRun == DEB) begin mSwDeb = mSwRaw2; mSwRun = 0; end
            end else begin
                mSwRun = 0;
            end
            mBtnRaw2 = mBtnRaw1; mBtnRaw1 = int'(b);
            mSwRaw2 = mSwRaw1;   mSwRaw1 = int'(s);
        end
    endtask

    task automatic checkOutput();
        checkVal("state", 32'(state), 32'(mMode));
        checkVal("ctr_en", 32'(ctr_en), 32'(mEn));
        checkVal("ctr_clr", 32'(ctr_clr), 32'(mClr));
        checkVal("done", 32'(done), (mMode == 3) ? 32'd1 : 32'd0);
        checkVal("ctr_val", 32'(ctr_val), 32'(mCount));
        checkVal("en_clr_exclusive", 32'(ctr_en & ctr_clr), 32'd0);
        if (ctr_en === 1'b1) enPulses++;
        if (ctr_clr === 1'b1) clrPulses++;
        if (ctr_en === 1'b1 && ctr_val == 16'(LIM)) enAtLimit++;
    endtask

    // One clock cycle: drive inputs away from the edge, let the counter
    // react just after the edge, then compare on the falling edge.
    task automatic applyStimulus(input bit b, input bit s, input bit r);
        btn_in = b;
        sw_in = s;
        rst_n = r;
        envEn = ctr_en;
        envClr = ctr_clr;
        @(posedge clk);
        modelEdge(b, s, r);
        #1;
        if (!r || envClr === 1'b1) envCount = 0;
        else if (envEn === 1'b1) envCount++;
        ctr_val = 16'(envCount);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b, curSw, 1'b1);
    endtask

    task automatic pressPattern();
        hold(1'b1, 4);
        hold(1'b0, 4);
    endtask

    task automatic waitForState(input string name, input int s, input int bound);
        int i;
        i = 0;
        while (i < bound && state !== 2'(s)) begin
            applyStimulus(1'b0, curSw, 1'b1);
            i++;
        end
        checkVal(name, 32'(state), 32'(s));
    endtask

    initial begin
        int enBefore;
        int clrBefore;
        bit b;
        bit s;
        bit r;
        int btnLeft;
        int swLeft;

        $display("[TB] starting");
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkVal("reset_state", 32'(state), 32'd0);
        checkVal("reset_en", 32'(ctr_en), 32'd0);
        checkVal("reset_clr", 32'(ctr_clr), 32'd0);
        checkVal("reset_done", 32'(done), 32'd0);
        hold(1'b0, 3);

        // Short glitch must be rejected
        enBefore = enPulses;
        hold(1'b1, 3);
        hold(1'b0, 12);
        checkVal("glitch_state", 32'(state), 32'd0);
        checkVal("glitch_en", 32'(enPulses - enBefore), 32'd0);

        // Clean press: acts on the 8th edge after btn_in is first sampled
        hold(1'b1, 4);
        hold(1'b0, 3);
        checkVal("press_latency_early", 32'(state), 32'd0);
        hold(1'b0, 1);
        checkVal("press_latency", 32'(state), 32'd1);
        enBefore = enPulses;
        pressPattern();
        checkVal("pause_state", 32'(state), 32'd2);
        checkVal("pause_val", 32'(ctr_val), 32'd2);
        checkVal("pause_run_pulses", 32'(enPulses - enBefore), 32'd2);

        // Two single steps
        curSw = 1'b1;
        hold(1'b0, 10);
        enBefore = enPulses;
        pressPattern(); hold(1'b0, 4);
        pressPattern(); hold(1'b0, 4);
        checkVal("step_pulses", 32'(enPulses - enBefore), 32'd2);
        checkVal("step_val", 32'(ctr_val), 32'd4);
        checkVal("step_state", 32'(state), 32'd2);

        // Resume continuous run and finish at LIMIT
        curSw = 1'b0;
        hold(1'b0, 10);
        hold(1'b1, 4);
        waitForState("resume_run", 1, 20);
        waitForState("reach_done", 3, 40);
        checkVal("done_val", 32'(ctr_val), 32'(LIM));
        checkVal("done_flag", 32'(done), 32'd1);
        checkVal("no_en_at_limit", 32'(enAtLimit), 32'd0);

        // Restart from DONE
        clrBefore = clrPulses;
        hold(1'b1, 4);
        waitForState("restart_idle", 0, 20);
        hold(1'b0, 6);
        checkVal("restart_clr_pulses", 32'(clrPulses - clrBefore), 32'd1);
        checkVal("restart_val", 32'(ctr_val), 32'd0);

        // Second episode: pause at 2, step up to LIMIT, terminal step
        pressPattern();
        pressPattern();
        checkVal("ep2_pause_val", 32'(ctr_val), 32'd2);
        curSw = 1'b1;
        hold(1'b0, 10);
        for (int k = 0; k < 3; k++) begin
            pressPattern();
            hold(1'b0, 4);
        end
        checkVal("ep2_step_val", 32'(ctr_val), 32'(LIM));
        checkVal("ep2_step_state", 32'(state), 32'd2);
        enBefore = enPulses;
        pressPattern();
        hold(1'b0, 4);
        checkVal("terminal_step_state", 32'(state), 32'd3);
        checkVal("terminal_step_en", 32'(enPulses - enBefore), 32'd0);
        checkVal("terminal_step_val", 32'(ctr_val), 32'(LIM));
        hold(1'b1, 4);
        waitForState("ep2_restart_idle", 0, 20);
        hold(1'b0, 6);

        // Reset in RUN with the prescaler at 2
        hold(1'b1, 4);
        hold(1'b0, 4);
        checkVal("midrun_entry", 32'(state), 32'd1);
        hold(1'b0, 2);
        applyStimulus(1'b0, curSw, 1'b0);
        checkVal("midrun_reset_state", 32'(state), 32'd0);
        checkVal("midrun_reset_en", 32'(ctr_en), 32'd0);
        checkVal("midrun_reset_clr", 32'(ctr_clr), 32'd0);
        checkVal("midrun_reset_done", 32'(done), 32'd0);
        curSw = 1'b0;
        hold(1'b0, 10);

        // Randomized phase against the model
        b = 1'b0;
        s = 1'b0;
        btnLeft = 0;
        swLeft = 20;
        for (int c = 0; c < 3000; c++) begin
            if (btnLeft == 0) begin
                b = ~b;
                btnLeft = int'($urandom_range(1, 12));
            end
            btnLeft--;
            if (swLeft == 0) begin
                s = ~s;
                swLeft = int'($urandom_range(4, 40));
            end
            swLeft--;
            r = ($urandom_range(0, 499) != 0);
            applyStimulus(b, s, r);
        end
        checkVal("random_no_en_at_limit", 32'(enAtLimit), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
